// File: rtl/multi_chan_delay_timer.sv
// rtl/multi_chan_delay_timer.sv - NCH independent periodic/one-shot delay timers sharing one period-write port
module multi_chan_delay_timer #(
  parameter int NCH        = 4,
  parameter int CBITS      = 14,
  parameter int DEF_PERIOD = 10000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NCH-1:0]         en,
  input  logic [NCH-1:0]         mode,
  input  logic [NCH-1:0]         start,
  input  logic                   cfg_we,
  input  logic [$clog2(NCH)-1:0] cfg_ch,
  input  logic [CBITS-1:0]       cfg_period,
  input  logic [NCH-1:0]         err_clr,
  output logic [NCH-1:0]         sig,
  output logic [NCH-1:0]         flg,
  output logic [NCH-1:0]         err,
  output logic [NCH-1:0]         err_sticky,
  output logic [NCH-1:0]         busy
);

  localparam int CHW = $clog2(NCH);

  typedef enum logic {IDLE, RUN} state_t;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    state_t           state, state_nxt;
    logic [CBITS-1:0] cnt, cnt_nxt;
    logic [CBITS-1:0] per;
    logic             sticky;
    logic             run;
    logic             at_term;

    assign run     = (state == RUN);
    assign at_term = (cnt >= per);

    // Disable beats a start, which beats normal counting; a one-shot retrigger
    // beats the terminal count in the same cycle.
    always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      if (!en[i]) begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end else if (state == IDLE) begin
        if (!mode[i] || start[i]) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end
      end else if (mode[i] && start[i]) begin
        cnt_nxt = '0;
      end else if (at_term) begin
        cnt_nxt = '0;
        if (mode[i]) state_nxt = IDLE;
      end else begin
        cnt_nxt = cnt + CBITS'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        state  <= IDLE;
        cnt    <= '0;
        per    <= CBITS'(DEF_PERIOD);
        sticky <= 1'b0;
      end else begin
        state <= state_nxt;
        cnt   <= cnt_nxt;
        if (cfg_we && (cfg_ch == CHW'(i))) per <= cfg_period;
        if (err[i])          sticky <= 1'b1;
        else if (err_clr[i]) sticky <= 1'b0;
      end
    end

    // Count above period only happens after the period is reprogrammed below it.
    assign sig[i]        = run && at_term;
    assign flg[i]        = run && !at_term;
    assign err[i]        = run && (cnt > per);
    assign busy[i]       = run;
    assign err_sticky[i] = sticky;
  end

endmodule

// File: tb/tb_multi_chan_delay_timer.sv
// tb/tb_multi_chan_delay_timer.sv - randomized and directed self-checking bench for multi_chan_delay_timer
module tb_multi_chan_delay_timer;

  localparam int NCH = 4;
  localparam int CBITS = 4;
  localparam int DEF_PERIOD = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic [NCH-1:0]   en, mode, start, err_clr;
  logic             cfg_we;
  logic [1:0]       cfg_ch;
  logic [CBITS-1:0] cfg_period;
  logic [NCH-1:0]   sig, flg, err, err_sticky, busy;

  multi_chan_delay_timer #(.NCH(NCH), .CBITS(CBITS), .DEF_PERIOD(DEF_PERIOD)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .start(start),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_period(cfg_period), .err_clr(err_clr),
    .sig(sig), .flg(flg), .err(err), .err_sticky(err_sticky), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference: each channel remembers whether it is timing, how many cycles
  // have elapsed since it (re)started, its period and its latched error.
  int m_elapsed [NCH];
  bit m_active  [NCH];
  int m_per     [NCH];
  bit m_sticky  [NCH];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < NCH; i++) begin
      bit overrun;
      int old_per;
      overrun = m_active[i] && (m_elapsed[i] > m_per[i]);
      old_per = m_per[i];
      if (rst) begin
        m_active[i] = 0; m_elapsed[i] = 0; m_per[i] = DEF_PERIOD; m_sticky[i] = 0;
      end else begin
        if (overrun) m_sticky[i] = 1;
        else if (err_clr[i]) m_sticky[i] = 0;
        if (cfg_we && cfg_ch == 2'(i)) m_per[i] = int'(cfg_period);
        if (!en[i]) begin
          m_active[i] = 0; m_elapsed[i] = 0;
        end else if (!m_active[i]) begin
          if (!mode[i] || start[i]) begin m_active[i] = 1; m_elapsed[i] = 0; end
        end else if (mode[i] && start[i]) begin
          m_elapsed[i] = 0;
        end else if (m_elapsed[i] >= old_per) begin
          m_elapsed[i] = 0;
          if (mode[i]) m_active[i] = 0;
        end else begin
          m_elapsed[i] = m_elapsed[i] + 1;
        end
      end
    end
  endtask

  task automatic compare_all();
    logic [NCH-1:0] e_sig, e_flg, e_err, e_sticky, e_busy;
    for (int i = 0; i < NCH; i++) begin
      e_sig[i]    = m_active[i] && (m_elapsed[i] >= m_per[i]);
      e_flg[i]    = m_active[i] && (m_elapsed[i] <  m_per[i]);
      e_err[i]    = m_active[i] && (m_elapsed[i] >  m_per[i]);
      e_sticky[i] = m_sticky[i];
      e_busy[i]   = m_active[i];
    end
    check("sig", 32'(sig), 32'(e_sig));
    check("flg", 32'(flg), 32'(e_flg));
    check("err", 32'(err), 32'(e_err));
    check("err_sticky", 32'(err_sticky), 32'(e_sticky));
    check("busy", 32'(busy), 32'(e_busy));
  endtask

  task automatic tick();
    model_step();
    @(negedge clk);
    compare_all();
    start = '0; cfg_we = 1'b0; err_clr = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); rst = 1'b0;
  endtask

  initial begin
    int first, second;
    rst = 1'b1; en = '0; mode = '0; start = '0; cfg_we = 1'b0;
    cfg_ch = '0; cfg_period = '0; err_clr = '0;
    for (int i = 0; i < NCH; i++) begin
      m_elapsed[i] = 0; m_active[i] = 0; m_per[i] = 0; m_sticky[i] = 0;
    end

    do_reset();
    check("rst_outputs", {sig, flg, err, err_sticky, busy}, 32'h0);

    // periodic ch0: ticks after 6 and 12 edges with en
    en = 4'b0001; mode = 4'b0000; first = -1; second = -1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (sig[0] && first < 0) first = k;
      else if (sig[0] && second < 0) second = k;
    end
    check("periodic_first", 32'(first), 32'd6);
    check("periodic_second", 32'(second), 32'd12);

    // one-shot ch1: pulse 6 edges after start, idle from edge 7
    en = 4'b0011; mode = 4'b0010; tick();
    start = 4'b0010; tick(); first = -1;
    for (int k = 2; k <= 8; k++) begin
      tick();
      if (sig[1] && first < 0) first = k;
      if (k == 7) check("oneshot_busy_drop", 32'(busy[1]), 32'd0);
    end
    check("oneshot_pulse", 32'(first), 32'd6);

    // retrigger driven in cycle t+3 moves the pulse to t+9
    start = 4'b0010; tick(); first = -1;
    for (int k = 2; k <= 12; k++) begin
      if (k == 4) start = 4'b0010;
      tick();
      if (sig[1] && first < 0) first = k;
    end
    check("retrigger_pulse", 32'(first), 32'd9);

    // reprogram ch2 below its count
    do_reset();
    en = 4'b0100; mode = 4'b0000;
    for (int k = 1; k <= 5; k++) tick();
    cfg_we = 1'b1; cfg_ch = 2'd2; cfg_period = 4'd2; tick();
    check("reprog_err", 32'(err[2]), 32'd1);
    check("reprog_sig", 32'(sig[2]), 32'd1);
    first = -1; second = -1;
    for (int k = 7; k <= 12; k++) begin
      tick();
      if (k == 7) check("reprog_err_gone", 32'(err[2]), 32'd0);
      if (sig[2] && first < 0) first = k;
      else if (sig[2] && second < 0) second = k;
    end
    check("reprog_tick1", 32'(first), 32'd9);
    check("reprog_tick2", 32'(second), 32'd12);
    check("sticky_held", 32'(err_sticky[2]), 32'd1);
    err_clr = 4'b0100; tick();
    check("sticky_cleared", 32'(err_sticky[2]), 32'd0);

    // simultaneous start and period write on ch3; ch0 keeps default period
    do_reset();
    en = 4'b1001; mode = 4'b1000; tick();
    start = 4'b1000; cfg_we = 1'b1; cfg_ch = 2'd3; cfg_period = 4'd1; tick();
    tick();
    check("simul_sig3", 32'(sig[3]), 32'd1);
    first = -1;
    for (int k = 4; k <= 8; k++) begin
      tick();
      if (sig[0] && first < 0) first = k;
    end
    check("simul_ch0_period", 32'(first), 32'd6);

    // disable mid-count, then reset mid-run
    tick(); tick();
    en = 4'b1000; tick();
    check("disable_busy0", 32'(busy[0]), 32'd0);
    en = 4'b1111; mode = 4'b0000;
    for (int k = 0; k < 3; k++) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    check("midrun_rst", {sig, flg, err, err_sticky, busy}, 32'h0);
    en = 4'b0100; first = -1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (sig[2] && first < 0) first = k;
    end
    check("rst_period_restored", 32'(first), 32'd6);

    // randomized traffic against the reference
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < NCH; i++) begin
        en[i]      = ($urandom_range(0, 15) != 0);
        start[i]   = ($urandom_range(0, 7) == 0);
        err_clr[i] = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 31) == 0) mode[i] = ~mode[i];
      end
      cfg_we     = ($urandom_range(0, 7) == 0);
      cfg_ch     = 2'($urandom_range(0, 3));
      cfg_period = 4'($urandom_range(0, 15));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
